code_memory_arbiter: RTL and testbench

- Shares the single-port synchronous text memory between two requesters:
  - the instruction-fetch port (read-only);
  - the data load/store port (read/write, byte-enabled).
- Arbitrates each cycle and drives the memory port.
- Tracks which requester owns the in-flight read and returns its data one cycle later.
- Sits between the core's fetch/LSU buses and the text memory macro; range and alignment faults are reported without touching memory.

---
 rtl/code_memory_arbiter_pkg.sv | 16 +
 rtl/code_mem_addr_check.sv | 21 ++
 rtl/code_memory_arbiter.sv | 114 +++++++++++
 tb/tb_code_memory_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/code_memory_arbiter_pkg.sv
// Shared constants for the text-memory arbiter: region bounds, starvation
// limit and the response-owner encoding carried through the pipeline.
package code_memory_arbiter_pkg;

    localparam logic [31:0] BEGINNING_TEXT = 32'h0040_0000;
    localparam int          TEXT_WIDTH     = 14;
    localparam logic [31:0] END_TEXT       = BEGINNING_TEXT + (32'd1 << TEXT_WIDTH) - 32'd1;
    localparam int          MAX_WAIT       = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

endpackage

// File: rtl/code_mem_addr_check.sv
// Range/alignment check and word-offset translation for the granted address.
// The region base is assumed word aligned, so the word offset is a subtraction
// on the word-index bits only.
module code_mem_addr_check
    import code_memory_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE  = code_memory_arbiter_pkg::BEGINNING_TEXT,
    parameter int          WIDTH = code_memory_arbiter_pkg::TEXT_WIDTH
) (
    input  logic [31:0]      addr,
    output logic [WIDTH-3:0] word,
    output logic             fault
);

    localparam logic [31:0]      LAST      = BASE + (32'd1 << WIDTH) - 32'd1;
    localparam logic [WIDTH-3:0] BASE_WORD = BASE[WIDTH-1:2];

    assign word  = addr[WIDTH-1:2] - BASE_WORD;
    assign fault = (addr < BASE) || (addr > LAST) || (addr[1:0] != 2'b00);

endmodule

// File: rtl/code_memory_arbiter.sv
// Two-requester arbiter for the single-port text memory. Data normally wins,
// fetch is promoted after MAX_WAIT denied cycles. Responses come back one
// cycle after grant, routed by a registered owner tag.
module code_memory_arbiter
    import code_memory_arbiter_pkg::*;
#(
    parameter logic [31:0] BEGINNING_TEXT = code_memory_arbiter_pkg::BEGINNING_TEXT,
    parameter int          TEXT_WIDTH     = code_memory_arbiter_pkg::TEXT_WIDTH,
    parameter int          MAX_WAIT       = code_memory_arbiter_pkg::MAX_WAIT
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    input  logic                  iFetchReq,
    input  logic [31:0]           iFetchAddr,
    output logic                  oFetchGnt,
    output logic                  oFetchValid,
    output logic [31:0]           oFetchData,
    output logic                  oFetchErr,
    input  logic                  iDataReq,
    input  logic                  iDataWe,
    input  logic [3:0]            iDataBe,
    input  logic [31:0]           iDataAddr,
    input  logic [31:0]           iDataWData,
    output logic                  oDataGnt,
    output logic                  oDataValid,
    output logic [31:0]           oDataRData,
    output logic                  oDataErr,
    output logic [TEXT_WIDTH-3:0] oMemAddr,
    output logic [3:0]            oMemByteEn,
    output logic [31:0]           oMemWData,
    output logic                  oMemWren,
    input  logic [31:0]           iMemRData
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]            wait_cnt;
    logic                  fetch_win;
    logic                  data_win;
    logic                  gnt_any;
    logic [31:0]           gnt_addr;
    logic [TEXT_WIDTH-3:0] gnt_word;
    logic                  gnt_fault;
    logic [TEXT_WIDTH-3:0] mem_addr_q;
    owner_t                owner_q;
    logic                  fault_q;
    logic                  we_q;
    logic                  mem_access;

    // Grants are held off while in reset so every output reads zero.
    assign fetch_win = iRST_n && iFetchReq && (!iDataReq || (wait_cnt == WAIT_LIMIT));
    assign data_win  = iRST_n && iDataReq && !fetch_win;
    assign gnt_any   = fetch_win || data_win;
    assign gnt_addr  = fetch_win ? iFetchAddr : iDataAddr;

    code_mem_addr_check #(
        .BASE  (BEGINNING_TEXT),
        .WIDTH (TEXT_WIDTH)
    ) u_addr_check (
        .addr  (gnt_addr),
        .word  (gnt_word),
        .fault (gnt_fault)
    );

    // Faulted requests are acknowledged but never reach the macro.
    assign mem_access = gnt_any && !gnt_fault;
    assign oFetchGnt  = fetch_win;
    assign oDataGnt   = data_win;
    assign oMemWren   = mem_access && data_win && iDataWe;
    assign oMemWData  = oMemWren ? iDataWData : 32'h0;
    assign oMemAddr   = mem_access ? gnt_word : mem_addr_q;
    assign oMemByteEn = !mem_access ? 4'h0 : (oMemWren ? iDataBe : 4'hF);

    // Starvation counter: counts denied fetch cycles, saturating at the limit.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wait_cnt <= 4'd0;
        end else if (iFetchReq && !fetch_win) begin
            if (wait_cnt != WAIT_LIMIT)
                wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Memory address is held between accesses.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            mem_addr_q <= '0;
        else if (mem_access)
            mem_addr_q <= gnt_word;
    end

    // Response tag for the access issued this cycle, consumed next cycle.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            owner_q <= OWN_NONE;
            fault_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            owner_q <= fetch_win ? OWN_FETCH : (data_win ? OWN_DATA : OWN_NONE);
            fault_q <= gnt_any && gnt_fault;
            we_q    <= data_win && iDataWe;
        end
    end

    assign oFetchValid = (owner_q == OWN_FETCH);
    assign oFetchErr   = oFetchValid && fault_q;
    assign oFetchData  = (oFetchValid && !fault_q) ? iMemRData : 32'h0;
    assign oDataValid  = (owner_q == OWN_DATA);
    assign oDataErr    = oDataValid && fault_q;
    assign oDataRData  = (oDataValid && !fault_q && !we_q) ? iMemRData : 32'h0;

endmodule

// File: tb/tb_code_memory_arbiter.sv
// Directed bench for code_memory_arbiter with a behavioural text memory.
// The driver pushes hand-computed responses; the monitor pops and compares.
module tb_code_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt, fetch_valid, fetch_err;
    logic [31:0] fetch_data;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_valid, data_err;
    logic [31:0] data_rdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:4095];
    logic        do_init;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    code_memory_arbiter dut (
        .iCLK        (clk),
        .iRST_n      (rst_n),
        .iFetchReq   (fetch_req),
        .iFetchAddr  (fetch_addr),
        .oFetchGnt   (fetch_gnt),
        .oFetchValid (fetch_valid),
        .oFetchData  (fetch_data),
        .oFetchErr   (fetch_err),
        .iDataReq    (data_req),
        .iDataWe     (data_we),
        .iDataBe     (data_be),
        .iDataAddr   (data_addr),
        .iDataWData  (data_wdata),
        .oDataGnt    (data_gnt),
        .oDataValid  (data_valid),
        .oDataRData  (data_rdata),
        .oDataErr    (data_err),
        .oMemAddr    (mem_addr),
        .oMemByteEn  (mem_be),
        .oMemWData   (mem_wdata),
        .oMemWren    (mem_wren),
        .iMemRData   (mem_rdata)
    );

    // Synchronous single-port memory: read returns the pre-write contents.
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= 32'hC0DE_0000 | i;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'hAAAA_BBBB;
        end else if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_valid || data_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got fv=%0b dv=%0b expected none", fetch_valid, data_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_owner", {30'd0, data_valid, fetch_valid}, {30'd0, e.own});
                    if (e.own == 2'd1) begin
                        chk("fetch_data", fetch_data, e.data);
                        chk("fetch_err", fetch_err, e.err);
                    end else begin
                        chk("data_rdata", data_rdata, e.data);
                        chk("data_err", data_err, e.err);
                    end
                end
            end
        end
    end

    // eg: expected grant 0=none 1=fetch 2=data
    task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                         input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd,
                         input logic [1:0] eg, input logic [31:0] ed, input logic ee);
        exp_t e;
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = fa;
        data_req   = dr;
        data_we    = dw;
        data_be    = db;
        data_addr  = da;
        data_wdata = dd;
        #1;
        chk("fetch_gnt", fetch_gnt, eg == 2'd1);
        chk("data_gnt", data_gnt, eg == 2'd2);
        if (eg != 2'd0) begin
            e.own  = eg;
            e.data = ed;
            e.err  = ee;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0);
    endtask

    logic [31:0] alt_exp [0:7];

    initial begin
        alt_exp[0] = 32'hC0DE_0000; alt_exp[1] = 32'hC0DE_0002;
        alt_exp[2] = 32'hDEAD_BEEF; alt_exp[3] = 32'hC0DE_0006;
        alt_exp[4] = 32'hAAAA_5678; alt_exp[5] = 32'hC0DE_000A;
        alt_exp[6] = 32'hCAFE_F00D; alt_exp[7] = 32'hC0DE_000E;

        rst_n = 1'b0;
        do_init = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h0040_0000;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = 32'h0040_0000; data_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        chk("rst_fetch_gnt", fetch_gnt, 0);
        chk("rst_data_gnt", data_gnt, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_data_err", data_err, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_data_rdata", data_rdata, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        do_init = 1'b0;
        fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        rst_n = 1'b1;

        // single fetch
        drive(1, 32'h0040_0010, 0, 0, 4'h0, 0, 0, 2'd1, 32'hDEAD_BEEF, 0);
        chk("f_mem_addr", mem_addr, 12'd4);
        chk("f_mem_be", mem_be, 4'hF);
        chk("f_mem_wren", mem_wren, 0);
        idle();

        // partial write then read-back of the same word
        drive(0, 0, 1, 1, 4'b0011, 32'h0040_0020, 32'h1234_5678, 2'd2, 32'h0, 0);
        chk("w_mem_wren", mem_wren, 1);
        chk("w_mem_addr", mem_addr, 12'd8);
        chk("w_mem_be", mem_be, 4'h3);
        chk("w_mem_wdata", mem_wdata, 32'h1234_5678);
        drive(0, 0, 1, 0, 4'h0, 32'h0040_0020, 0, 2'd2, 32'hAAAA_5678, 0);
        chk("r_mem_wren", mem_wren, 0);
        chk("r_mem_addr", mem_addr, 12'd8);
        idle();

        // faults and region boundaries
        drive(1, 32'h0040_0002, 0, 0, 4'h0, 0, 0, 2'd1, 32'h0, 1);
        chk("fm_mem_wren", mem_wren, 0);
        drive(0, 0, 1, 0, 4'h0, 32'h0000_1000, 0, 2'd2, 32'h0, 1);
        chk("fl_mem_wren", mem_wren, 0);
        drive(0, 0, 1, 1, 4'hF, 32'h0040_4000, 32'h5555_5555, 2'd2, 32'h0, 1);
        chk("fh_mem_wren", mem_wren, 0);
        drive(1, 32'h0040_3FFC, 0, 0, 4'h0, 0, 0, 2'd1, 32'hC0DE_0FFF, 0);
        chk("last_mem_addr", mem_addr, 12'hFFF);
        drive(0, 0, 1, 0, 4'h0, 32'h003F_FFFC, 0, 2'd2, 32'h0, 1);
        idle();

        // starvation: data wins MAX_WAIT cycles, then fetch
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                drive(1, 32'h0040_0010, 1, 0, 4'h0, 32'h0040_0004, 0, 2'd1, 32'hDEAD_BEEF, 0);
            else
                drive(1, 32'h0040_0010, 1, 0, 4'h0, 32'h0040_0004, 0, 2'd2, 32'hC0DE_0001, 0);
        end
        idle();

        // write and fetch to the same word: serialised, fetch sees new data
        drive(1, 32'h0040_0030, 1, 1, 4'hF, 32'h0040_0030, 32'hCAFE_F00D, 2'd2, 32'h0, 0);
        drive(1, 32'h0040_0030, 0, 0, 4'h0, 0, 0, 2'd1, 32'hCAFE_F00D, 0);
        idle();

        // alternating owners back to back
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                drive(1, 32'h0040_0000 + 32'(8 * i), 0, 0, 4'h0, 0, 0, 2'd1, alt_exp[i], 0);
            else
                drive(0, 0, 1, 0, 4'h0, 32'h0040_0000 + 32'(8 * i), 0, 2'd2, alt_exp[i], 0);
        end
        idle();

        // reset right after a grant: the response must be dropped
        drive(1, 32'h0040_0000, 0, 0, 4'h0, 0, 0, 2'd1, 32'h0, 0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_fetch_valid", fetch_valid, 0);
        chk("mid_rst_data_valid", data_valid, 0);
        chk("mid_rst_fetch_data", fetch_data, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        drive(1, 32'h0040_0018, 0, 0, 4'h0, 0, 0, 2'd1, 32'hC0DE_0006, 0);
        idle();
        idle();

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
